// File: rtl/serial_mag_comp.sv
// serial_mag_comp: MSB-first digit-serial magnitude comparator (g/e/l).
// Optional SERIAL_MAG_COMP_EARLY_EXIT_EN ends a run at the first differing digit.
module serial_mag_comp #(
  parameter int WIDTH = 6,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_mag_comp: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] ra, rb, ra_n, rb_n, msk;
  logic [CW-1:0]    cnt, cnt_n;
  logic [DIGIT-1:0] sa, sb;
  logic             gi, ei, gi_n, ei_n;
  logic             g_n, e_n, l_n, done_n;
  logic             step_g, step_e, fin;

  // Signed mode flips the MSB so plain unsigned digit compares order correctly.
  assign msk    = {sgn, {(WIDTH-1){1'b0}}};
  assign sa     = ra[WIDTH-1 -: DIGIT];
  assign sb     = rb[WIDTH-1 -: DIGIT];
  assign step_g = gi | (ei & (sa > sb));
  assign step_e = ei & (sa == sb);
  assign busy   = (state == RUN);

`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
  assign fin = (cnt == '0) || !step_e;
`else
  assign fin = (cnt == '0);
`endif

  // Next-state and datapath update: load on start, one digit per RUN cycle.
  always_comb begin
    state_n = state;
    ra_n    = ra;
    rb_n    = rb;
    cnt_n   = cnt;
    gi_n    = gi;
    ei_n    = ei;
    g_n     = g;
    e_n     = e;
    l_n     = l;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          ra_n    = a ^ msk;
          rb_n    = b ^ msk;
          gi_n    = 1'b0;
          ei_n    = 1'b1;
          cnt_n   = LAST;
          state_n = RUN;
        end
      end
      RUN: begin
        ra_n  = ra << DIGIT;
        rb_n  = rb << DIGIT;
        gi_n  = step_g;
        ei_n  = step_e;
        cnt_n = cnt - CW'(1);
        if (fin) begin
          g_n     = step_g;
          e_n     = step_e;
          l_n     = ~step_g & ~step_e;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any run in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      cnt   <= '0;
      gi    <= 1'b0;
      ei    <= 1'b0;
      g     <= 1'b0;
      e     <= 1'b0;
      l     <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      ra    <= ra_n;
      rb    <= rb_n;
      cnt   <= cnt_n;
      gi    <= gi_n;
      ei    <= ei_n;
      g     <= g_n;
      e     <= e_n;
      l     <= l_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp: directed bench for serial_mag_comp.
// Instances with DIGIT = 1, 2, 3 on WIDTH = 6 share clock and reset.
module tb_serial_mag_comp;

`ifdef SERIAL_MAG_COMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       st [3];
  logic       sg [3];
  logic [5:0] aa [3];
  logic [5:0] bb [3];
  logic       bz [3];
  logic       dn [3];
  logic       go [3];
  logic       eo [3];
  logic       lo [3];

  int total = 0;
  int bad   = 0;

  serial_mag_comp #(.WIDTH(6), .DIGIT(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sgn(sg[0]),
    .a(aa[0]), .b(bb[0]), .busy(bz[0]), .done(dn[0]),
    .g(go[0]), .e(eo[0]), .l(lo[0])
  );

  serial_mag_comp #(.WIDTH(6), .DIGIT(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sgn(sg[1]),
    .a(aa[1]), .b(bb[1]), .busy(bz[1]), .done(dn[1]),
    .g(go[1]), .e(eo[1]), .l(lo[1])
  );

  serial_mag_comp #(.WIDTH(6), .DIGIT(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sgn(sg[2]),
    .a(aa[2]), .b(bb[2]), .busy(bz[2]), .done(dn[2]),
    .g(go[2]), .e(eo[2]), .l(lo[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] gel(input int k);
    return {go[k], eo[k], lo[k]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One comparison with latency, hold and pulse checks.
  task automatic cmp(input int k, input logic s,
                     input logic [5:0] av, input logic [5:0] bv,
                     input int lat, input logic [2:0] ex,
                     input logic [2:0] pv, input bit poke,
                     input string tag);
    int n;
    @(negedge clk);
    st[k] = 1'b1; sg[k] = s; aa[k] = av; bb[k] = bv;
    @(negedge clk);
    st[k] = 1'b0; sg[k] = 1'b0; aa[k] = '0; bb[k] = '0;
    chk({tag, "_busy"}, 32'(bz[k]), 32'd1);
    chk({tag, "_hold"}, 32'(gel(k)), 32'(pv));
    n = 1;
    while (!dn[k] && n < 20) begin
      st[k] = (poke && n == 2);
      @(negedge clk);
      n++;
    end
    st[k] = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_gel"}, 32'(gel(k)), 32'(ex));
    chk({tag, "_idle"}, 32'(bz[k]), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(dn[k]), 32'd0);
    if (poke) begin
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        chk({tag, "_nodone"}, 32'({dn[k], bz[k]}), 32'd0);
      end
    end
  endtask

  // Back-to-back sweep: each new start is issued in the done cycle.
  task automatic sweep(input int k, input bit full, input string tag);
    int lim;
    int n;
    logic [5:0] av, bv;
    logic       gt;
    logic [2:0] ex;
    lim = full ? 4096 : 512;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < lim; i++) begin
        if (full) begin
          av = 6'(i >> 6);
          bv = 6'(i);
        end else begin
          av = 6'(i);
          bv = 6'(i * 29 + 7);
        end
        gt = s[0] ? ($signed(av) > $signed(bv)) : (av > bv);
        ex = {gt, av == bv, !gt && av != bv};
        if (i == 0) @(negedge clk);
        st[k] = 1'b1; sg[k] = s[0]; aa[k] = av; bb[k] = bv;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!dn[k] && n < 20);
        chk(tag, 32'({dn[k], gel(k)}), 32'({1'b1, ex}));
      end
      st[k] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int nd;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; sg[k] = 1'b0; aa[k] = '0; bb[k] = '0;
    end
    #12;
    for (int k = 0; k < 3; k++)
      chk("reset", 32'({bz[k], dn[k], gel(k)}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cmp(0, 1'b0, 6'd37, 6'd37, 7, 3'b010, 3'b000, 1'b0, "eq37");
    cmp(0, 1'b0, 6'd63, 6'd1, EE ? 2 : 7, 3'b100, 3'b010, 1'b0, "u63_1");
    cmp(0, 1'b1, 6'd63, 6'd1, EE ? 2 : 7, 3'b001, 3'b100, 1'b0, "s63_1");
    cmp(0, 1'b1, 6'd32, 6'd31, EE ? 2 : 7, 3'b001, 3'b001, 1'b0, "s32_31");
    cmp(1, 1'b0, 6'd40, 6'd39, EE ? 3 : 4, 3'b100, 3'b000, 1'b1, "d2_40_39");
    cmp(0, 1'b0, 6'd32, 6'd0, EE ? 2 : 7, 3'b100, 3'b001, 1'b0, "ee32_0");

    @(negedge clk);
    st[0] = 1'b1; sg[0] = 1'b0; aa[0] = 6'd5; bb[0] = 6'd9;
    @(negedge clk);
    st[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("rst_run", 32'({bz[0], dn[0], gel(0)}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      nd += int'(dn[0]);
    end
    chk("rst_nodone", 32'(nd), 32'd0);
    cmp(0, 1'b0, 6'd9, 6'd5, EE ? 4 : 7, 3'b100, 3'b000, 1'b0, "after_rst");

    sweep(2, 1'b1, "sweep_d3");
    sweep(0, 1'b0, "sweep_d1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
